// File: rtl/wb_commit_pkg.sv
// Shared constants and types for the writeback commit slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_commit_pkg;

    localparam int InstAddrBus = 32;
    localparam int RegBus      = 32;
    localparam int RegAddrBus  = 5;
    localparam int WbFifoDepth = 4;

    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic RstEnable    = 1'b1;

    // Where the pair loaded into the output register comes from this cycle.
    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_HEAD   = 2'd1,
        SRC_BYPASS = 2'd2
    } issue_src_e;

endpackage

// File: rtl/wb_commit_if.sv
// Result-pair handshake plus the two register-file write ports.
// Latency: n/a (wiring only).
// Backpressure: in_ready from the commit unit gates in_valid.
interface wb_commit_if import wb_commit_pkg::*; #(
    parameter int PC_W   = InstAddrBus,
    parameter int DATA_W = RegBus,
    parameter int RA_W   = RegAddrBus
) ();

    logic              in_valid;
    logic              in_ready;
    logic              in_we_0;
    logic              in_we_1;
    logic [RA_W-1:0]   in_waddr_0;
    logic [RA_W-1:0]   in_waddr_1;
    logic [DATA_W-1:0] in_wdata_0;
    logic [DATA_W-1:0] in_wdata_1;
    logic [PC_W-1:0]   in_pc_0;
    logic [PC_W-1:0]   in_pc_1;
    logic              commit_stall;
    logic              flush;

    logic              we_1;
    logic [RA_W-1:0]   waddr_1;
    logic [DATA_W-1:0] wdata_1;
    logic [PC_W-1:0]   pc_o_1;
    logic              we_2;
    logic [RA_W-1:0]   waddr_2;
    logic [DATA_W-1:0] wdata_2;
    logic [PC_W-1:0]   pc_o_2;
    logic [1:0]        commit_cnt;
    logic              empty;

    modport slave (
        input  in_valid, in_we_0, in_we_1, in_waddr_0, in_waddr_1,
               in_wdata_0, in_wdata_1, in_pc_0, in_pc_1, commit_stall, flush,
        output in_ready, we_1, waddr_1, wdata_1, pc_o_1,
               we_2, waddr_2, wdata_2, pc_o_2, commit_cnt, empty
    );

    modport master (
        output in_valid, in_we_0, in_we_1, in_waddr_0, in_waddr_1,
               in_wdata_0, in_wdata_1, in_pc_0, in_pc_1, commit_stall, flush,
        input  in_ready, we_1, waddr_1, wdata_1, pc_o_1,
               we_2, waddr_2, wdata_2, pc_o_2, commit_cnt, empty
    );

endinterface

// File: rtl/wb_pair_fifo.sv
// Synchronous in-order FIFO of W-bit entries with push/pop/clear and occupancy count.
// Latency: pushed entry visible at dout the cycle after the push (registered storage).
// Backpressure: push ignored when full, pop ignored when empty; clear wins over both.
module wb_pair_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    import wb_commit_pkg::*;

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_C  = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]  count_q, count_d;
    logic         do_push, do_pop;
    logic         ptr_msb_unused;

    // Pointers wrap modulo DEPTH, so their top bit only exists for width symmetry.
    function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
        return (p == LAST_C) ? '0 : p + ONE_C;
    endfunction

    assign full           = (count_q == DEPTH_C);
    assign empty          = (count_q == '0);
    assign count          = count_q;
    assign dout           = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push        = push && !full;
    assign do_pop         = pop && !empty;
    assign ptr_msb_unused = wr_ptr_q[AW] ^ rd_ptr_q[AW];

    // Next pointers, count and storage; clear empties the queue without touching storage.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q[AW-1:0]] = din;
                wr_ptr_d                = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + ONE_C;
                2'b01:   count_d = count_q - ONE_C;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/wb_commit.sv
// Dual-issue writeback commit: buffers result pairs and drives two sanitised RF write ports.
// Latency: 1 cycle from acceptance to ports when the FIFO is empty and not stalled.
// Backpressure: in_ready = FIFO not full; accepted pairs are never dropped except by flush/reset.
module wb_commit import wb_commit_pkg::*; #(
    parameter int DEPTH  = WbFifoDepth,
    parameter int PC_W   = InstAddrBus,
    parameter int DATA_W = RegBus,
    parameter int RA_W   = RegAddrBus
) (
    input  logic        clk,
    input  logic        rst,
    wb_commit_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic              we;
        logic [RA_W-1:0]   waddr;
        logic [DATA_W-1:0] wdata;
        logic [PC_W-1:0]   pc;
    } lane_t;

    typedef struct packed {
        lane_t l1;
        lane_t l0;
    } pair_t;

    pair_t      in_pair, head_pair, issue_pair;
    pair_t      out_q, out_d;
    issue_src_e src;
    logic       in_ready, accept, push, pop;
    logic       fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;

    // x0 writes are dropped; on a same-register dual write the younger lane wins.
    function automatic pair_t sanitise(input pair_t p);
        pair_t s;
        s = p;
        if (s.l0.waddr == '0) s.l0.we = WriteDisable;
        if (s.l1.waddr == '0) s.l1.we = WriteDisable;
        if (s.l0.we && s.l1.we && (s.l0.waddr == s.l1.waddr)) s.l0.we = WriteDisable;
        return s;
    endfunction

    assign in_pair.l0 = '{we: bus.in_we_0, waddr: bus.in_waddr_0,
                          wdata: bus.in_wdata_0, pc: bus.in_pc_0};
    assign in_pair.l1 = '{we: bus.in_we_1, waddr: bus.in_waddr_1,
                          wdata: bus.in_wdata_1, pc: bus.in_pc_1};

    assign in_ready     = !fifo_full;
    assign accept       = bus.in_valid && in_ready && !bus.flush;
    assign bus.in_ready = in_ready;

    wb_pair_fifo #(
        .W     ($bits(pair_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (bus.flush),
        .push  (push),
        .pop   (pop),
        .din   (in_pair),
        .dout  (head_pair),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Pick the issue source: buffered head first, else bypass the incoming pair.
    always_comb begin
        src = SRC_NONE;
        if (!bus.commit_stall) begin
            if (!fifo_empty) begin
                src = SRC_HEAD;
            end else if (accept) begin
                src = SRC_BYPASS;
            end
        end
        pop        = (src == SRC_HEAD);
        push       = accept && (src != SRC_BYPASS);
        issue_pair = (src == SRC_HEAD) ? head_pair : in_pair;
    end

    // Output register: load a sanitised pair on issue, otherwise hold fields with writes off.
    always_comb begin
        out_d       = out_q;
        out_d.l0.we = WriteDisable;
        out_d.l1.we = WriteDisable;
        if (!bus.flush && (src != SRC_NONE)) begin
            out_d = sanitise(issue_pair);
        end
    end

    // Output stage flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign bus.we_1       = out_q.l0.we;
    assign bus.waddr_1    = out_q.l0.waddr;
    assign bus.wdata_1    = out_q.l0.wdata;
    assign bus.pc_o_1     = out_q.l0.pc;
    assign bus.we_2       = out_q.l1.we;
    assign bus.waddr_2    = out_q.l1.waddr;
    assign bus.wdata_2    = out_q.l1.wdata;
    assign bus.pc_o_2     = out_q.l1.pc;
    assign bus.commit_cnt = {1'b0, out_q.l0.we} + {1'b0, out_q.l1.we};
    assign bus.empty      = (fifo_count == '0) && !out_q.l0.we && !out_q.l1.we;

endmodule
